// File: rtl/bpu_resolve.sv
// Branch prediction resolve unit: holds outstanding predictions in a circular
// queue, compares each against the in-order resolution from execute, and raises
// a one-cycle redirect with the corrected fetch PC on a misprediction.
module bpu_resolve #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_prdt_vld,
    output logic            o_prdt_rdy,
    input  logic [XLEN-1:0] i_prdt_pc,
    input  logic            i_prdt_taken,
    input  logic [XLEN-1:0] i_prdt_tpc,
    input  logic            i_rslv_vld,
    input  logic            i_rslv_taken,
    input  logic [XLEN-1:0] i_rslv_tpc,
    output logic            o_flush,
    output logic [XLEN-1:0] o_flush_pc,
    output logic            o_rslv_err,
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispred_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [XLEN-1:0]   q_pc  [DEPTH];
    logic [XLEN-1:0]   q_tpc [DEPTH];
    logic [DEPTH-1:0]  q_taken;

    logic              full;
    logic              empty;
    logic              push;
    logic              rslv_act;
    logic              rslv_bad;
    logic              mispred;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_tpc;
    logic              head_taken;
    logic [XLEN-1:0]   correct_pc;

    // Queue status, handshakes and misprediction detection against the head entry
    always_comb begin
        full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty      = (wr_ptr == rd_ptr);
        o_prdt_rdy = !full && !o_flush;
        push       = i_prdt_vld && o_prdt_rdy;
        // Resolves are ignored entirely while a redirect is being presented.
        rslv_act   = i_rslv_vld && !empty && !o_flush;
        rslv_bad   = i_rslv_vld && empty && !o_flush;
        head_pc    = q_pc[rd_ptr[AW-1:0]];
        head_tpc   = q_tpc[rd_ptr[AW-1:0]];
        head_taken = q_taken[rd_ptr[AW-1:0]];
        mispred    = rslv_act &&
                     ((i_rslv_taken != head_taken) ||
                      (i_rslv_taken && head_taken && (i_rslv_tpc != head_tpc)));
        correct_pc = i_rslv_taken ? i_rslv_tpc : head_pc + XLEN'(4);
    end

    // Prediction storage; the write pointer decides whether an entry is live
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_pc[wr_ptr[AW-1:0]]    <= i_prdt_pc;
            q_tpc[wr_ptr[AW-1:0]]   <= i_prdt_tpc;
            q_taken[wr_ptr[AW-1:0]] <= i_prdt_taken;
        end
    end

    // Pointers, redirect pulse, error flag and saturating statistics
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            o_flush       <= 1'b0;
            o_flush_pc    <= '0;
            o_rslv_err    <= 1'b0;
            o_branch_cnt  <= '0;
            o_mispred_cnt <= '0;
        end else begin
            o_flush <= mispred;
            // On a mispredict the read pointer catches the pre-push write
            // pointer, so a push accepted in the same cycle is dropped.
            if (mispred) begin
                rd_ptr     <= wr_ptr;
                o_flush_pc <= correct_pc;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (rslv_act) begin
                    rd_ptr <= rd_ptr + (AW+1)'(1);
                end
            end
            if (rslv_bad) begin
                o_rslv_err <= 1'b1;
            end
            if (rslv_act && (o_branch_cnt != '1)) begin
                o_branch_cnt <= o_branch_cnt + 32'd1;
            end
            if (mispred && (o_mispred_cnt != '1)) begin
                o_mispred_cnt <= o_mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpu_resolve.sv
// Self-checking bench for bpu_resolve: directed vectors with a flush-PC
// scoreboard drained by an independent monitor.
module tb_bpu_resolve;

    logic        i_clk;
    logic        i_rstn;
    logic        i_prdt_vld;
    logic        o_prdt_rdy;
    logic [31:0] i_prdt_pc;
    logic        i_prdt_taken;
    logic [31:0] i_prdt_tpc;
    logic        i_rslv_vld;
    logic        i_rslv_taken;
    logic [31:0] i_rslv_tpc;
    logic        o_flush;
    logic [31:0] o_flush_pc;
    logic        o_rslv_err;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispred_cnt;

    int checks   = 0;
    int failures = 0;
    logic [31:0] flush_sb[$];

    bpu_resolve #(.DEPTH(4), .XLEN(32)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_prdt_vld   (i_prdt_vld),
        .o_prdt_rdy   (o_prdt_rdy),
        .i_prdt_pc    (i_prdt_pc),
        .i_prdt_taken (i_prdt_taken),
        .i_prdt_tpc   (i_prdt_tpc),
        .i_rslv_vld   (i_rslv_vld),
        .i_rslv_taken (i_rslv_taken),
        .i_rslv_tpc   (i_rslv_tpc),
        .o_flush      (o_flush),
        .o_flush_pc   (o_flush_pc),
        .o_rslv_err   (o_rslv_err),
        .o_branch_cnt (o_branch_cnt),
        .o_mispred_cnt(o_mispred_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_push(input logic v, input logic [31:0] pc, input logic t, input logic [31:0] tpc);
        i_prdt_vld   = v;
        i_prdt_pc    = pc;
        i_prdt_taken = t;
        i_prdt_tpc   = tpc;
    endtask

    task automatic set_rslv(input logic v, input logic t, input logic [31:0] tpc);
        i_rslv_vld   = v;
        i_rslv_taken = t;
        i_rslv_tpc   = tpc;
    endtask

    // Monitor: every flush pulse must match the oldest expected redirect PC.
    always @(negedge i_clk) begin
        if (i_rstn && o_flush) begin
            checks++;
            if (flush_sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_flush: got flush_pc 0x%08h expected no flush", o_flush_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = flush_sb.pop_front();
                if (o_flush_pc !== exp_pc) begin
                    failures++;
                    $display("FAIL sb_flush_pc: got 0x%08h expected 0x%08h", o_flush_pc, exp_pc);
                end
            end
        end
    end

    initial begin
        i_rstn = 1'b0;
        set_push(1'b0, '0, 1'b0, '0);
        set_rslv(1'b0, 1'b0, '0);
        cyc();
        cyc();
        i_rstn = 1'b1;
        check("rst_rdy", 32'(o_prdt_rdy), 32'd1);
        check("rst_flush", 32'(o_flush), 32'd0);
        check("rst_flush_pc", o_flush_pc, 32'h0);
        check("rst_err", 32'(o_rslv_err), 32'd0);
        check("rst_bcnt", o_branch_cnt, 32'd0);
        check("rst_mcnt", o_mispred_cnt, 32'd0);

        // Correctly predicted taken branch
        set_push(1'b1, 32'h100, 1'b1, 32'h80);
        cyc();
        set_push(1'b0, '0, 1'b0, '0);
        set_rslv(1'b1, 1'b1, 32'h80);
        cyc();
        set_rslv(1'b0, 1'b0, '0);
        check("t35_flush", 32'(o_flush), 32'd0);
        check("t35_bcnt", o_branch_cnt, 32'd1);
        check("t35_mcnt", o_mispred_cnt, 32'd0);

        // Predicted taken, actually not taken: redirect to pc+4
        set_push(1'b1, 32'h200, 1'b1, 32'h1F0);
        cyc();
        set_push(1'b0, '0, 1'b0, '0);
        set_rslv(1'b1, 1'b0, 32'h0);
        flush_sb.push_back(32'h204);
        cyc();
        set_rslv(1'b0, 1'b0, '0);
        check("t36_flush", 32'(o_flush), 32'd1);
        check("t36_flush_pc", o_flush_pc, 32'h204);
        check("t36_mcnt", o_mispred_cnt, 32'd1);
        check("t36_bcnt", o_branch_cnt, 32'd2);
        check("t36_rdy_in_flush", 32'(o_prdt_rdy), 32'd0);
        cyc();
        check("t36_flush_done", 32'(o_flush), 32'd0);
        check("t36_flush_pc_hold", o_flush_pc, 32'h204);
        check("t36_rdy_after", 32'(o_prdt_rdy), 32'd1);

        // Fill to full, then push+pop together: push rejected, head popped
        for (int i = 0; i < 4; i++) begin
            check("t37_rdy_fill", 32'(o_prdt_rdy), 32'd1);
            set_push(1'b1, 32'h300 + 32'(i) * 32'h10, 1'b0, 32'h0);
            cyc();
        end
        check("t37_full_rdy", 32'(o_prdt_rdy), 32'd0);
        set_push(1'b1, 32'h400, 1'b0, 32'h0);
        set_rslv(1'b1, 1'b0, 32'h0);
        cyc();
        set_push(1'b0, '0, 1'b0, '0);
        set_rslv(1'b0, 1'b0, '0);
        check("t37_rdy_after_pop", 32'(o_prdt_rdy), 32'd1);
        check("t37_bcnt", o_branch_cnt, 32'd3);
        // Drain the remaining three back to back
        set_rslv(1'b1, 1'b0, 32'h0);
        cyc();
        cyc();
        cyc();
        set_rslv(1'b0, 1'b0, '0);
        check("t37_bcnt_drain", o_branch_cnt, 32'd6);
        check("t37_mcnt_drain", o_mispred_cnt, 32'd1);
        // Exactly four pushes must refill it, proving the rejected push was not stored
        for (int i = 0; i < 4; i++) begin
            check("t37_rdy_refill", 32'(o_prdt_rdy), 32'd1);
            set_push(1'b1, 32'h700 + 32'(i) * 32'h10, 1'b0, 32'h0);
            cyc();
        end
        set_push(1'b0, '0, 1'b0, '0);
        check("t37_refull", 32'(o_prdt_rdy), 32'd0);
        set_rslv(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cyc();
        set_rslv(1'b0, 1'b0, '0);
        check("t37_bcnt_final", o_branch_cnt, 32'd10);

        // Three entries; head mispredicts while a push is offered
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 32'h500 + 32'(i) * 32'h10, 1'b0, 32'h0);
            cyc();
        end
        set_push(1'b1, 32'h600, 1'b0, 32'h0);
        set_rslv(1'b1, 1'b1, 32'h40);
        flush_sb.push_back(32'h40);
        cyc();
        // Push and resolve stay asserted through the flush cycle and must be ignored
        check("t38_flush", 32'(o_flush), 32'd1);
        check("t38_flush_pc", o_flush_pc, 32'h40);
        check("t38_rdy_in_flush", 32'(o_prdt_rdy), 32'd0);
        check("t38_mcnt", o_mispred_cnt, 32'd2);
        check("t38_bcnt", o_branch_cnt, 32'd11);
        cyc();
        set_push(1'b0, '0, 1'b0, '0);
        set_rslv(1'b0, 1'b0, '0);
        check("t38_flush_done", 32'(o_flush), 32'd0);
        check("t38_bcnt_ignored", o_branch_cnt, 32'd11);
        check("t38_err_clear", 32'(o_rslv_err), 32'd0);
        check("t38_rdy_after", 32'(o_prdt_rdy), 32'd1);

        // Resolve on the (now empty) queue: sticky error, no count, no flush
        set_rslv(1'b1, 1'b1, 32'h0);
        cyc();
        set_rslv(1'b0, 1'b0, '0);
        check("t39_err", 32'(o_rslv_err), 32'd1);
        check("t39_bcnt", o_branch_cnt, 32'd11);
        check("t39_mcnt", o_mispred_cnt, 32'd2);
        check("t39_noflush", 32'(o_flush), 32'd0);
        cyc();
        cyc();
        check("t39_err_sticky", 32'(o_rslv_err), 32'd1);
        i_rstn = 1'b0;
        cyc();
        i_rstn = 1'b1;
        check("t39_rst_err", 32'(o_rslv_err), 32'd0);
        check("t39_rst_bcnt", o_branch_cnt, 32'd0);
        check("t39_rst_mcnt", o_mispred_cnt, 32'd0);
        check("t39_rst_rdy", 32'(o_prdt_rdy), 32'd1);
        check("t39_rst_flush_pc", o_flush_pc, 32'h0);

        // Nine pushes overlapped with in-order correct resolves; pointers wrap twice
        set_push(1'b1, 32'h1000, 1'b0, 32'h2000);
        cyc();
        for (int i = 1; i <= 9; i++) begin
            logic       pt;
            logic [31:0] ptpc;
            pt   = ((i - 1) % 2) == 1;
            ptpc = 32'h2000 + 32'(i - 1) * 32'h10;
            if (i <= 8) begin
                set_push(1'b1, 32'h1000 + 32'(i) * 32'h8, (i % 2) == 1, 32'h2000 + 32'(i) * 32'h10);
            end else begin
                set_push(1'b0, '0, 1'b0, '0);
            end
            set_rslv(1'b1, pt, pt ? ptpc : 32'h0);
            cyc();
            check("t40_noflush", 32'(o_flush), 32'd0);
        end
        set_rslv(1'b0, 1'b0, '0);
        check("t40_bcnt", o_branch_cnt, 32'd9);
        check("t40_mcnt", o_mispred_cnt, 32'd0);
        check("t40_err", 32'(o_rslv_err), 32'd0);

        cyc();
        cyc();
        check("sb_drained", 32'(flush_sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bpu_resolve.md
BPU_RESOLVE -- requirements
Module: bpu_resolve

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of prediction-queue entries (power of two, >= 2).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-003 SHALL have port i_rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port i_prdt_vld, input, 1 bit: the predictor pushes one prediction record.
REQ-005 SHALL have port o_prdt_rdy, output, 1 bit: the queue accepts a push this cycle.
REQ-006 SHALL have port i_prdt_pc, input, `xlen_def: PC of the predicted branch or jump.
REQ-007 SHALL have port i_prdt_taken, input, 1 bit: predicted direction.
REQ-008 SHALL have port i_prdt_tpc, input, `xlen_def: predicted target address.
REQ-009 SHALL have port i_rslv_vld, input, 1 bit: execute resolves the oldest outstanding branch, in program order.
REQ-010 SHALL have port i_rslv_taken, input, 1 bit: actual direction.
REQ-011 SHALL have port i_rslv_tpc, input, `xlen_def: actual target address.
REQ-012 SHALL have port o_flush, output, 1 bit: one-cycle redirect/flush pulse.
REQ-013 SHALL have port o_flush_pc, output, `xlen_def: corrected fetch PC, valid while o_flush=1.
REQ-014 SHALL have port o_rslv_err, output, 1 bit: sticky protocol error.
REQ-015 SHALL have port o_branch_cnt, output, 32 bits: number of resolved branches.
REQ-016 SHALL have port o_mispred_cnt, output, 32 bits: number of mispredictions.

Function
REQ-017 Queue SHALL be a circular FIFO: DEPTH entries of {pc, taken, tpc}; read/write pointers are log2(DEPTH)+1 bits including a wrap bit.
REQ-018 Full SHALL be: pointer indices equal and wrap bits differ. Empty SHALL be: pointers identical.
REQ-019 o_prdt_rdy SHALL be combinational: !full & !o_flush. Full is evaluated on registered state; a same-cycle pop does not free a slot for a same-cycle push.
REQ-020 A push SHALL be accepted when i_prdt_vld & o_prdt_rdy. The entry is written at the write pointer, which then increments modulo 2*DEPTH.
REQ-021 A resolve SHALL act only when i_rslv_vld & !empty. It compares against the head entry and pops it.
REQ-022 A push SHALL NOT be visible to a resolve in the same cycle.
REQ-023 A mispredict SHALL be detected when (i_rslv_taken != head.taken) | (i_rslv_taken & head.taken & (i_rslv_tpc != head.tpc)).
REQ-024 Correct PC SHALL be: i_rslv_taken ? i_rslv_tpc : head.pc + 4, computed modulo 2^xlen.
REQ-025 On a mispredict, o_flush SHALL be 1 and o_flush_pc SHALL equal the correct PC in the cycle after the resolve, for exactly one cycle. Otherwise o_flush=0 and o_flush_pc holds its last value.
REQ-026 On a mispredict, the queue SHALL be emptied at the clock edge ending the resolve cycle (read pointer := write pointer). A push accepted in that same cycle SHALL be discarded.
REQ-027 While o_flush=1, pushes SHALL be blocked (o_prdt_rdy=0) and resolves SHALL be ignored.
REQ-028 i_rslv_vld while empty SHALL set o_rslv_err=1 until reset. There is no pop, no counter change and no flush.
REQ-029 o_branch_cnt SHALL increment on each acting resolve; o_mispred_cnt SHALL increment on each mispredict. Both saturate at 0xFFFFFFFF.
REQ-030 Back-to-back correct resolves SHALL be sustained at one per cycle with no bubbles.

Reset
REQ-031 When i_rstn=0 at a rising edge, the block SHALL set pointers to 0 (queue empty), o_flush=0, o_flush_pc=0, o_rslv_err=0 and both counters to 0.
REQ-032 After reset, o_prdt_rdy SHALL be 1.
REQ-033 Reset asserted mid-operation SHALL discard all entries and cancel any pending flush.
REQ-034 Queue data storage need not be reset.

Verification
REQ-035 Push {pc=0x100, taken=1, tpc=0x80}, then resolve {taken=1, tpc=0x80} -> no flush; branch_cnt=1, mispred_cnt=0.
REQ-036 Push {pc=0x200, taken=1, tpc=0x1F0}, then resolve taken=0 -> next cycle o_flush=1 and o_flush_pc=0x204; mispred_cnt=1; queue empty.
REQ-037 Push 4 entries -> o_prdt_rdy=0. Then push and resolve in the same cycle -> the push is rejected and the head is popped; next cycle o_prdt_rdy=1.
REQ-038 Queue holds 3 entries; the head mispredicts on {taken=1, tpc=0x40} while a push is offered -> o_flush_pc=0x40, queue empty, the pushed entry is discarded, o_prdt_rdy=0 during the flush cycle.
REQ-039 Resolve on an empty queue -> o_rslv_err=1 and stays 1; counters unchanged. Then i_rstn=0 for one edge -> o_rslv_err=0, counters 0, o_prdt_rdy=1.
REQ-040 Push 9 entries interleaved with correct resolves so the pointers wrap twice -> every resolve compares against the correct entry with no spurious flush.
